// File: rtl/vpu_cmd_queue_if.sv
// Command-queue bus between the CPU decode/writeback stage, the queue and the VPU.
// Macro VPU_CMD_FLUSH_EN adds the q_flush request line.
//   CPU side : cmd_valid, cmd_instr, cmd_obj, v_in, ro_in, q_flush -> queue
//              cmd_rdy, cmd_drop, q_count, busy                   <- queue
//   VPU side : VPU_rdy -> queue
//              VPU_start_out, VPU_fill, VPU_op, VPU_code, VPU_obj_type,
//              VPU_obj_color, VPU_obj_num, v_out, ro_out           <- queue
// slave modport is used by the queue, master modport by the environment.
interface vpu_cmd_queue_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_V  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OBJ_W  = 5
);
  localparam int unsigned V_W   = NUM_V * DATA_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic [15:0]       cmd_instr;
  logic [OBJ_W-1:0]  cmd_obj;
  logic [V_W-1:0]    v_in;
  logic [DATA_W-1:0] ro_in;
  logic              cmd_rdy;
  logic              cmd_drop;
`ifdef VPU_CMD_FLUSH_EN
  logic              q_flush;
`endif
  logic              VPU_rdy;
  logic              VPU_start_out;
  logic              VPU_fill;
  logic [3:0]        VPU_op;
  logic [3:0]        VPU_code;
  logic [1:0]        VPU_obj_type;
  logic [2:0]        VPU_obj_color;
  logic [OBJ_W-1:0]  VPU_obj_num;
  logic [V_W-1:0]    v_out;
  logic [DATA_W-1:0] ro_out;
  logic [CNT_W-1:0]  q_count;
  logic              busy;

  modport slave (
`ifdef VPU_CMD_FLUSH_EN
    input  q_flush,
`endif
    input  cmd_valid, cmd_instr, cmd_obj, v_in, ro_in, VPU_rdy,
    output cmd_rdy, cmd_drop, VPU_start_out, VPU_fill, VPU_op, VPU_code,
           VPU_obj_type, VPU_obj_color, VPU_obj_num, v_out, ro_out,
           q_count, busy
  );

  modport master (
`ifdef VPU_CMD_FLUSH_EN
    output q_flush,
`endif
    output cmd_valid, cmd_instr, cmd_obj, v_in, ro_in, VPU_rdy,
    input  cmd_rdy, cmd_drop, VPU_start_out, VPU_fill, VPU_op, VPU_code,
           VPU_obj_type, VPU_obj_color, VPU_obj_num, v_out, ro_out,
           q_count, busy
  );
endinterface

// File: rtl/vpu_cmd_queue.sv
// VPU command queue: decodes CPU VPU commands at push time, buffers them with
// their operands in a DEPTH-entry FIFO and dispatches them one at a time to
// the VPU through a start/ready handshake (FILL commands use a fill pulse and
// need no handshake).
// Ports: clk, rst_n (async active-low), bus (vpu_cmd_queue_if.slave).
// Optional macro VPU_CMD_FLUSH_EN: enables bus.q_flush, which empties the FIFO
// without disturbing the command already handed to the VPU.
module vpu_cmd_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_V  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OBJ_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  vpu_cmd_queue_if.slave bus
);
  localparam int unsigned V_W   = NUM_V * DATA_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              fill;
    logic [3:0]        op;
    logic [3:0]        code;
    logic [1:0]        obj_type;
    logic [2:0]        obj_color;
    logic [OBJ_W-1:0]  obj_num;
    logic [V_W-1:0]    v;
    logic [DATA_W-1:0] ro;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACK  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_cmd_rdy;
  logic              r_cmd_drop;
  logic              r_start;
  logic              r_fill;
  logic              r_busy;
  entry_t            r_out;
  entry_t            w_dec;
  entry_t            w_head;
  logic              w_legal;
  logic              w_flush;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_start_nxt;
  logic              w_fill_nxt;
  logic              w_unused_instr;

`ifdef VPU_CMD_FLUSH_EN
  assign w_flush = bus.q_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Bits 8:4 of the instruction carry nothing the VPU needs.
  assign w_unused_instr = ^bus.cmd_instr[8:4];

  // Push-time decode of the instruction into the stored command fields.
  always_comb begin
    w_legal         = 1'b1;
    w_dec.fill      = 1'b0;
    w_dec.op        = 4'h0;
    w_dec.code      = {bus.cmd_instr[1:0], bus.cmd_instr[3:2]};
    w_dec.obj_type  = bus.cmd_instr[10:9];
    w_dec.obj_color = bus.cmd_instr[2:0];
    w_dec.obj_num   = bus.cmd_obj;
    w_dec.v         = bus.v_in;
    w_dec.ro        = bus.ro_in;
    case (bus.cmd_instr[15:11])
      5'b10000: w_dec.op = 4'h0;
      5'b10001: w_dec.op = 4'h0;
      5'b10010: w_dec.fill = 1'b1;
      5'b10011: w_dec.op = bus.cmd_instr[10] ? 4'h2 : 4'h1;
      5'b10100: w_dec.op = bus.cmd_instr[10] ? 4'h4 : 4'h3;
      5'b10101: begin
        w_dec.op   = bus.cmd_instr[10] ? 4'h6 : 4'h7;
        w_dec.code = bus.cmd_instr[3:0];
      end
      5'b10110: begin
        w_dec.op   = 4'h5;
        w_dec.code = bus.cmd_instr[3:0];
      end
      5'b10111: begin
        case (bus.cmd_instr[1:0])
          2'd1:    w_dec.op = 4'h8;
          2'd2:    w_dec.op = 4'h9;
          default: w_dec.op = 4'hA;
        endcase
      end
      5'b11000: w_dec.op = bus.cmd_instr[10] ? 4'hC : 4'hB;
      5'b11001: w_dec.op = 4'hF;
      default:  w_legal = 1'b0;
    endcase
  end

  // A flush swallows any push offered in the same cycle.
  assign w_fire = bus.cmd_valid && r_cmd_rdy && !w_flush;
  assign w_push = w_fire && w_legal;
  assign w_head = r_mem[r_rd_ptr];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; a FILL dispatch needs no handshake so IDLE is kept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_pop && !w_head.fill) w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (!bus.VPU_rdy)          w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.VPU_rdy)           w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: pop decision and the pulse values registered at the edge.
  always_comb begin
    w_pop       = 1'b0;
    w_start_nxt = 1'b0;
    w_fill_nxt  = 1'b0;
    if (r_state == S_IDLE && r_count != '0 && bus.VPU_rdy && !w_flush) begin
      w_pop       = 1'b1;
      w_fill_nxt  = w_head.fill;
      w_start_nxt = !w_head.fill;
    end
  end

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // FIFO pointers and the registered ready/occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cmd_rdy <= 1'b1;
    end else begin
      r_count   <= w_count_nxt;
      r_cmd_rdy <= (w_count_nxt != CNT_W'(DEPTH));
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful between wr and rd pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // Dispatch registers: fields hold until the next dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_start    <= 1'b0;
      r_fill     <= 1'b0;
      r_cmd_drop <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_start    <= w_start_nxt;
      r_fill     <= w_fill_nxt;
      r_cmd_drop <= w_fire && !w_legal;
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_pop) r_out <= w_head;
    end
  end

  assign bus.cmd_rdy       = r_cmd_rdy;
  assign bus.cmd_drop      = r_cmd_drop;
  assign bus.q_count       = r_count;
  assign bus.busy          = r_busy;
  assign bus.VPU_start_out = r_start;
  assign bus.VPU_fill      = r_fill;
  assign bus.VPU_op        = r_out.op;
  assign bus.VPU_code      = r_out.code;
  assign bus.VPU_obj_type  = r_out.obj_type;
  assign bus.VPU_obj_color = r_out.obj_color;
  assign bus.VPU_obj_num   = r_out.obj_num;
  assign bus.v_out         = r_out.v;
  assign bus.ro_out        = r_out.ro;

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Self-checking bench for vpu_cmd_queue: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
// Define VPU_CMD_FLUSH_EN to also exercise the flush request.
module tb_vpu_cmd_queue;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_V  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OBJ_W  = 5;
  localparam int unsigned V_W    = NUM_V * DATA_W;

  logic clk = 1'b0;
  logic rst_n;

  vpu_cmd_queue_if #(.DATA_W(DATA_W), .NUM_V(NUM_V), .DEPTH(DEPTH), .OBJ_W(OBJ_W)) bus ();

  vpu_cmd_queue #(.DATA_W(DATA_W), .NUM_V(NUM_V), .DEPTH(DEPTH), .OBJ_W(OBJ_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit                fill;
    int unsigned       op;
    int unsigned       code;
    int unsigned       otype;
    int unsigned       color;
    int unsigned       num;
    logic [V_W-1:0]    v;
    logic [DATA_W-1:0] ro;
  } ent_t;

  ent_t mq[$];
  int   m_state;   // 0 idle, 1 waiting for VPU to go busy, 2 waiting for VPU done
  ent_t e_out;
  bit   e_start, e_fill, e_drop;

  task automatic check(input string tag, input logic [V_W-1:0] obs, input logic [V_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Opcode table evaluated arithmetically on the instruction word.
  function automatic bit decode(input logic [15:0] ins, output bit fill,
                                output int unsigned op, output int unsigned code);
    int unsigned w, opc, b10, lo2, lo4;
    w    = ins;
    opc  = w / 2048;
    b10  = (w / 1024) % 2;
    lo2  = w % 4;
    lo4  = w % 16;
    fill = 0;
    op   = 0;
    code = lo2 * 4 + (w / 4) % 4;
    case (opc)
      16, 17: op = 0;
      18: fill = 1;
      19: op = (b10 != 0) ? 2 : 1;
      20: op = (b10 != 0) ? 4 : 3;
      21: begin op = (b10 != 0) ? 6 : 7; code = lo4; end
      22: begin op = 5; code = lo4; end
      23: op = (lo2 == 1) ? 8 : ((lo2 == 2) ? 9 : 10);
      24: op = (b10 != 0) ? 12 : 11;
      25: op = 15;
      default: return 0;
    endcase
    return 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state     = 0;
    e_out.fill  = 0;
    e_out.op    = 0;
    e_out.code  = 0;
    e_out.otype = 0;
    e_out.color = 0;
    e_out.num   = 0;
    e_out.v     = '0;
    e_out.ro    = '0;
    e_start = 0;
    e_fill  = 0;
    e_drop  = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT will sample.
  task automatic model_step();
    bit fire, legal, pop, f, flush;
    int unsigned op, code, w;
    ent_t n;
    flush = 0;
`ifdef VPU_CMD_FLUSH_EN
    flush = bus.q_flush;
`endif
    w     = bus.cmd_instr;
    fire  = bus.cmd_valid && (mq.size() < DEPTH) && !flush;
    legal = decode(bus.cmd_instr, f, op, code);
    pop   = (m_state == 0) && (mq.size() > 0) && bus.VPU_rdy && !flush;
    e_drop  = fire && !legal;
    e_start = 0;
    e_fill  = 0;
    if (m_state == 1 && !bus.VPU_rdy)      m_state = 2;
    else if (m_state == 2 && bus.VPU_rdy)  m_state = 0;
    if (pop) begin
      e_out   = mq.pop_front();
      e_fill  = e_out.fill;
      e_start = !e_out.fill;
      if (!e_out.fill) m_state = 1;
    end
    if (flush) mq.delete();
    if (fire && legal) begin
      n.fill  = f;
      n.op    = op;
      n.code  = code;
      n.otype = (w / 512) % 4;
      n.color = w % 8;
      n.num   = bus.cmd_obj;
      n.v     = bus.v_in;
      n.ro    = bus.ro_in;
      mq.push_back(n);
    end
  endtask

  task automatic compare_all();
    check("cmd_rdy",   bus.cmd_rdy,       (mq.size() < DEPTH));
    check("q_count",   bus.q_count,       mq.size());
    check("busy",      bus.busy,          (m_state != 0));
    check("start",     bus.VPU_start_out, e_start);
    check("fill",      bus.VPU_fill,      e_fill);
    check("drop",      bus.cmd_drop,      e_drop);
    check("op",        bus.VPU_op,        e_out.op);
    check("code",      bus.VPU_code,      e_out.code);
    check("obj_type",  bus.VPU_obj_type,  e_out.otype);
    check("obj_color", bus.VPU_obj_color, e_out.color);
    check("obj_num",   bus.VPU_obj_num,   e_out.num);
    check("v_out",     bus.v_out,         e_out.v);
    check("ro_out",    bus.ro_out,        e_out.ro);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit valid, input logic [15:0] instr, input int unsigned obj,
                       input logic [15:0] v0, input bit rdy);
    logic [V_W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[15:0] = v0;
    bus.cmd_valid = valid;
    bus.cmd_instr = instr;
    bus.cmd_obj   = OBJ_W'(obj);
    bus.v_in      = v;
    bus.ro_in     = DATA_W'($urandom);
    bus.VPU_rdy   = rdy;
  endtask

  // Idle CPU, VPU that goes busy for two cycles after each start pulse.
  task automatic run_vpu(input int n);
    int cnt;
    cnt = bus.VPU_start_out ? 2 : 0;
    for (int i = 0; i < n; i++) begin
      drive(0, 16'h0000, 0, 16'h0000, (cnt == 0));
      if (cnt > 0) cnt--;
      step();
      if (bus.VPU_start_out) cnt = 2;
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_cmd_rdy"}, bus.cmd_rdy, 1);
    check({tag, "_q_count"}, bus.q_count, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_start"},   bus.VPU_start_out, 0);
    check({tag, "_op"},      bus.VPU_op, 0);
    check({tag, "_v_out"},   bus.v_out, 0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0;
    drive(0, 16'h0000, 0, 16'h0000, 0);
`ifdef VPU_CMD_FLUSH_EN
    bus.q_flush = 1'b0;
`endif
    #12;
    async_reset_check("reset");

    // DRAW with V0=0x1234: start pulse one cycle after the push.
    drive(1, 16'h8000, 3, 16'h1234, 1);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    check("draw_start", bus.VPU_start_out, 1);
    check("draw_op",    bus.VPU_op, 0);
    check("draw_v0",    bus.v_out[15:0], 16'h1234);
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0000, 0, 16'h0000, 0);
      step();
    end
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    check("draw_done_busy", bus.busy, 0);

    // Five pushes against a stalled VPU: only four fit.
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: ins = 16'h8001;
        1: ins = 16'h9C02;
        2: ins = 16'hA00D;
        3: ins = 16'hB00E;
        default: ins = 16'hC400;
      endcase
      drive(1, ins, i + 1, 16'(i), 0);
      step();
    end
    check("full_count", bus.q_count, 4);
    check("full_rdy",   bus.cmd_rdy, 0);
    run_vpu(30);

    // ROT and TRAN decode.
    drive(1, 16'hAC0B, 7, 16'h0001, 1);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    check("rot_op",   bus.VPU_op, 4'h6);
    check("rot_code", bus.VPU_code, 4'hB);
    run_vpu(6);
    drive(1, 16'hA006, 8, 16'h0002, 1);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    check("tran_op",   bus.VPU_op, 4'h3);
    check("tran_code", bus.VPU_code, 4'h9);
    run_vpu(6);

    // FILL followed by DRAW: fill pulse, then the start pulse on the next cycle.
    drive(1, 16'h9005, 9, 16'h0003, 1);
    step();
    drive(1, 16'h8000, 10, 16'h0004, 1);
    step();
    check("fill_pulse", bus.VPU_fill, 1);
    check("fill_start", bus.VPU_start_out, 0);
    check("fill_color", bus.VPU_obj_color, 5);
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    check("after_fill_start", bus.VPU_start_out, 1);
    check("after_fill_fill",  bus.VPU_fill, 0);
    run_vpu(6);

    // Illegal opcode is dropped.
    drive(1, 16'hD000, 1, 16'h0000, 1);
    step();
    check("drop_pulse", bus.cmd_drop, 1);
    check("drop_count", bus.q_count, 0);
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();

    // Reset while in WAIT_DONE with two entries queued.
    drive(1, 16'h8000, 2, 16'h0005, 1);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    drive(1, 16'h8800, 3, 16'h0006, 0);
    step();
    drive(1, 16'h9800, 4, 16'h0007, 0);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 0);
    step();
    check("pre_rst_count", bus.q_count, 2);
    check("pre_rst_busy",  bus.busy, 1);
    async_reset_check("midop_reset");

`ifdef VPU_CMD_FLUSH_EN
    // Flush with one command in flight and three queued.
    drive(1, 16'h8000, 5, 16'h0008, 1);
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hA000, 11 + i, 16'(i), 0);
      step();
    end
    check("pre_flush_count", bus.q_count, 3);
    drive(1, 16'h8000, 20, 16'h0009, 0);
    bus.q_flush = 1'b1;
    step();
    bus.q_flush = 1'b0;
    check("flush_count", bus.q_count, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'h0000, 0, 16'h0000, 1);
      step();
      check("flush_no_start", bus.VPU_start_out, 0);
    end
    check("flush_idle", bus.busy, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      int unsigned opc;
      opc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(16, 26);
      ins = 16'((opc << 11) | ($urandom & 32'h07FF));
      drive(($urandom_range(0, 9) < 6), ins, $urandom_range(0, 31),
            16'($urandom), ($urandom_range(0, 9) < 7));
`ifdef VPU_CMD_FLUSH_EN
      bus.q_flush = ($urandom_range(0, 29) == 0);
`endif
      step();
    end
`ifdef VPU_CMD_FLUSH_EN
    bus.q_flush = 1'b0;
`endif
    run_vpu(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_queue.md
Name: vpu_cmd_queue

Overview:
- Parametrised successor to the single-entry VPU instruction/operand register.
- The CPU pushes decoded VPU commands and their vector operands into a DEPTH-entry FIFO. The CPU stalls only when the FIFO is full, not for the whole VPU operation.
- A dispatch FSM drains the FIFO one command at a time using a start/ready handshake with the VPU.
- Sits between the CPU decode/writeback stage and the VPU command inputs.

Parameters:
DATA_W, 16, width of each vector operand and of RO
NUM_V, 8, number of vector operand registers carried per command
DEPTH, 4, FIFO entries; power of two, >= 2
OBJ_W, 5, object number width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  CPU presents a VPU command this cycle
cmd_instr  in  16  VPU instruction word
cmd_obj  in  OBJ_W  object number
v_in  in  NUM_V*DATA_W  packed operands; V0 in [DATA_W-1:0]
ro_in  in  DATA_W  RO operand
cmd_rdy  out  1  FIFO can accept a command (count < DEPTH)
cmd_drop  out  1  one-cycle pulse: illegal opcode discarded
VPU_rdy  in  1  VPU idle/ready
VPU_start_out  out  1  single-cycle start pulse
VPU_fill  out  1  single-cycle fill pulse
VPU_op  out  4  decoded op
VPU_code  out  4  decoded code
VPU_obj_type  out  2  instr[10:9]
VPU_obj_color  out  3  instr[2:0]
VPU_obj_num  out  OBJ_W  object number
v_out  out  NUM_V*DATA_W  operands of the dispatched command
ro_out  out  DATA_W  RO of the dispatched command
q_count  out  $clog2(DEPTH+1)  entries held
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cmd_rdy=1; FIFO empty; FSM in IDLE. Reset mid-operation discards all queued and in-flight commands.
- Push: the command is accepted when cmd_valid && cmd_rdy at the clock edge. Decode happens at push, and the FIFO stores the decoded fields, not the raw instruction.
- Decode, by instr[15:11]. Defaults: op=0, fill=0, code={i[1:0],i[3:2]}.
  - 10000 DRAW: op=0.
  - 10001 ELLI: op=0.
  - 10010 FILL: fill=1.
  - 10011 RMV: op = i[10] ? 2 : 1.
  - 10100 TRAN: op = i[10] ? 4 : 3.
  - 10101 ROT: op = i[10] ? 6 : 7; code = i[3:0].
  - 10110 SCALE: op=5; code = i[3:0].
  - 10111 REFLECT: op = 8 if i[1:0]=1, 9 if i[1:0]=2, else A.
  - 11000 MAT: op = i[10] ? C : B.
  - 11001 GETOBJ: op=F.
- Illegal opcodes: any other opcode is not enqueued, and cmd_drop pulses high the following cycle.
- Pointers: wrap modulo DEPTH.
- Simultaneous push and pop: q_count is unchanged.
- Push when full: cmd_rdy=0, so the command is not accepted and no state changes. The CPU holds cmd_valid.
- cmd_rdy and q_count are driven from registers only, never combinationally from cmd_valid.
- FSM states: IDLE, WAIT_ACK, WAIT_DONE.
  - IDLE, FIFO non-empty and VPU_rdy=1: pop the head and register all its fields onto the VPU_* outputs, v_out and ro_out.
    - Head is FILL: VPU_fill=1 for exactly the next cycle; stay in IDLE.
    - Otherwise: VPU_start_out=1 for exactly the next cycle; go to WAIT_ACK.
  - WAIT_ACK: VPU_start_out=0. On VPU_rdy=0, go to WAIT_DONE.
  - WAIT_DONE: on VPU_rdy=1, go to IDLE.
- Output stability: operand and field outputs hold from dispatch until the next dispatch.
- Minimum spacing: dispatch-to-dispatch is 1 cycle for consecutive FILLs, and 1 cycle after return to IDLE otherwise.
- Latency: 1 cycle from a push into an empty FIFO with idle VPU to the start (or fill) pulse.
- Pushes continue to be accepted in every FSM state.

Optional Feature:
- Macro VPU_CMD_FLUSH_EN.
- When defined: adds input port q_flush (1 bit).
  - q_flush=1 synchronously empties the FIFO (q_count=0 next cycle); a push in the same cycle is ignored.
  - The in-flight command is unaffected; the FSM completes its handshake.
  - Flush takes priority over push and pop.
- When undefined: no q_flush port; the FIFO empties only by dispatch or reset.

Test Plan:
- Reset, then push DRAW 0x8000 with V0=0x1234 and VPU_rdy=1 -> the next cycle has VPU_start_out=1 for one cycle, VPU_op=0, v_out[15:0]=0x1234. Then drop VPU_rdy for 3 cycles and raise it -> busy returns to 0.
- Push 5 commands (DEPTH=4) while VPU_rdy=0 -> the first 4 are accepted, cmd_rdy=0, q_count=4. Raise VPU_rdy -> the commands dispatch in FIFO order, and cmd_rdy=1 after the first pop.
- Push ROT 0xAC0B -> VPU_op=6, VPU_code=0xB. Push TRAN 0xA006 -> VPU_op=3, VPU_code={10,01}=0x9.
- Push FILL 0x9005 then DRAW -> VPU_fill pulses with VPU_start_out=0 and VPU_obj_color=5; on the following cycle the DRAW start pulse is issued.
- Push 0xD000 -> cmd_drop pulses, q_count unchanged. Assert rst_n=0 during WAIT_DONE with 2 entries queued -> all outputs 0 and q_count=0 immediately.
- With VPU_CMD_FLUSH_EN defined: 3 entries queued with one in flight, pulse q_flush -> q_count=0, the in-flight command completes, and no further start pulse is issued.
